// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - fetch/data arbiter onto one shared SRAM-like port
// Data side has priority; a starvation counter bounds how long a fetch waits.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  starve_cnt;

    logic        grant_inst;
    logic        grant_data;
    logic        resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            wstrb_q    <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            starve_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (grant_inst) begin
                owner      <= 1'b0;
                wr_q       <= 1'b0;
                size_q     <= 2'd2;
                wstrb_q    <= 4'd0;
                addr_q     <= inst_addr;
                wdata_q    <= 32'd0;
                starve_cnt <= 4'd0;
            end else if (grant_data) begin
                owner   <= 1'b1;
                wr_q    <= data_wr;
                size_q  <= data_size;
                wstrb_q <= data_wstrb;
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                // Only a waiting fetch counts as being starved.
                if (inst_req && starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        resp         = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_wstrb    = 4'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (inst_req && (starve_cnt == LIMIT || !data_req))
                        grant_inst = 1'b1;
                    else if (data_req)
                        grant_data = 1'b1;
                    inst_addr_ok = grant_inst;
                    data_addr_ok = grant_data;
                    if (grant_inst || grant_data)
                        state_next = ADDR;
                end
                ADDR: begin
                    mem_req   = 1'b1;
                    mem_wr    = wr_q;
                    mem_size  = size_q;
                    mem_wstrb = wstrb_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    if (mem_addr_ok)
                        state_next = DATA;
                end
                DATA: begin
                    resp = mem_data_ok;
                    if (resp) begin
                        state_next = IDLE;
                        if (owner) begin
                            data_data_ok = 1'b1;
                            // Store completions carry no read data.
                            data_rdata   = wr_q ? 32'd0 : mem_rdata;
                        end else begin
                            inst_data_ok = 1'b1;
                            inst_rdata   = mem_rdata;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        step();

        // Reset held with random inputs: every output must be 0.
        for (int i = 0; i < 3; i++) begin
            inst_req = 1'($urandom); inst_addr = $urandom; data_req = 1'($urandom);
            data_wr = 1'($urandom); data_size = 2'($urandom); data_wstrb = 4'($urandom);
            data_addr = $urandom; data_wdata = $urandom; mem_addr_ok = 1'($urandom);
            mem_data_ok = 1'($urandom); mem_rdata = $urandom;
            settle();
            check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
            check("rst_data_addr_ok", 32'(data_addr_ok), 0);
            check("rst_data_oks", {30'd0, inst_data_ok, data_data_ok}, 0);
            check("rst_rdata", inst_rdata | data_rdata, 0);
            check("rst_mem_ctl", {25'd0, mem_req, mem_wr, mem_size, mem_wstrb}, 0);
            check("rst_mem_addr", mem_addr | mem_wdata, 0);
            step();
        end

        // Single fetch, zero wait.
        reset = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C000000; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        settle();
        check("f_addr_ok_T0", 32'(inst_addr_ok), 1);
        check("f_data_addr_ok_T0", 32'(data_addr_ok), 0);
        check("f_mem_req_T0", 32'(mem_req), 0);
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b1;
        settle();
        check("f_mem_req_T1", 32'(mem_req), 1);
        check("f_mem_addr_T1", mem_addr, 32'h1C000000);
        check("f_mem_wr_T1", 32'(mem_wr), 0);
        check("f_mem_size_T1", 32'(mem_size), 2);
        check("f_addr_ok_T1", 32'(inst_addr_ok), 0);
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800C0C;
        settle();
        check("f_data_ok_T2", 32'(inst_data_ok), 1);
        check("f_rdata_T2", inst_rdata, 32'h02800C0C);
        check("f_other_ok_T2", 32'(data_data_ok), 0);
        check("f_mem_req_T2", 32'(mem_req), 0);
        step();
        mem_data_ok = 1'b0;
        settle();
        check("f_idle_data_ok", 32'(inst_data_ok), 0);
        check("f_idle_rdata", inst_rdata, 0);

        // Store with 2 address wait states and 1 data wait state.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b1100;
        data_addr = 32'h00001004; data_wdata = 32'hAABB0000;
        settle();
        check("st_addr_ok", 32'(data_addr_ok), 1);
        step();
        data_req = 1'b0; data_wdata = 32'h0; data_addr = 32'h0; data_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            mem_addr_ok = (i == 2);
            settle();
            check("st_mem_req", 32'(mem_req), 1);
            check("st_mem_ctl", {27'd0, mem_wr, mem_wstrb}, {27'd0, 1'b1, 4'b1100});
            check("st_mem_size", 32'(mem_size), 1);
            check("st_mem_addr", mem_addr, 32'h00001004);
            check("st_mem_wdata", mem_wdata, 32'hAABB0000);
            check("st_addr_ok_busy", 32'(data_addr_ok), 0);
            step();
        end
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hDEADBEEF;
        settle();
        check("st_data_wait", 32'(data_data_ok), 0);
        check("st_mem_req_data", 32'(mem_req), 0);
        step();
        mem_data_ok = 1'b1;
        settle();
        check("st_data_ok", 32'(data_data_ok), 1);
        check("st_rdata_zero", data_rdata, 0);
        check("st_inst_ok", 32'(inst_data_ok), 0);
        step();
        mem_data_ok = 1'b0;

        // Both requests held high: grants data x4, inst, data x4, inst.
        inst_req = 1'b1; inst_addr = 32'h1C000100;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h00002000; data_wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            logic exp_inst;
            logic [31:0] exp_cnt;
            exp_inst = (k % 5 == 4);
            exp_cnt = 32'(k % 5);
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
            settle();
            check("sv_cnt", 32'(dut.starve_cnt), exp_cnt);
            check("sv_inst_grant", 32'(inst_addr_ok), 32'(exp_inst));
            check("sv_data_grant", 32'(data_addr_ok), 32'(!exp_inst));
            step();
            mem_addr_ok = 1'b1;
            settle();
            check("sv_mem_addr", mem_addr, exp_inst ? 32'h1C000100 : 32'h00002000);
            step();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1000 + 32'(k);
            settle();
            check("sv_oks", {30'd0, inst_data_ok, data_data_ok}, exp_inst ? 32'd2 : 32'd1);
            check("sv_rdata", exp_inst ? inst_rdata : data_rdata, 32'h1000 + 32'(k));
            check("sv_other_rdata", exp_inst ? data_rdata : inst_rdata, 0);
            step();
        end
        inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;

        // Reset during DATA of a load to 0x2000 abandons it.
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00002000;
        settle();
        check("rm_addr_ok", 32'(data_addr_ok), 1);
        step();
        data_req = 1'b0; mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0; reset = 1'b1; mem_data_ok = 1'b0;
        settle();
        check("rm_data_ok_in_reset", 32'(data_data_ok), 0);
        step();
        reset = 1'b0;
        settle();
        check("rm_mem_req", 32'(mem_req), 0);
        check("rm_state_idle", 32'(dut.state), 0);
        for (int i = 0; i < 2; i++) begin
            mem_data_ok = 1'b1; mem_rdata = 32'h55AA55AA;
            settle();
            check("rm_late_resp", {30'd0, inst_data_ok, data_data_ok}, 0);
            check("rm_late_rdata", data_rdata, 0);
            step();
        end

        // Spurious mem_data_ok in IDLE, then in ADDR.
        mem_data_ok = 1'b1;
        settle();
        check("sp_idle", {30'd0, inst_data_ok, data_data_ok}, 0);
        inst_req = 1'b1; inst_addr = 32'h1C000200;
        #1;
        check("sp_accept", 32'(inst_addr_ok), 1);
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        check("sp_addr", {30'd0, inst_data_ok, data_data_ok}, 0);
        check("sp_addr_hold", 32'(mem_req), 1);
        step();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
        settle();
        check("sp_real_resp", 32'(inst_data_ok), 1);
        check("sp_real_rdata", inst_rdata, 32'h12345678);
        step();
        mem_data_ok = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

- Arbitrates the instruction-fetch port and the data-access port (the load/store path feeding the MEM stage) onto one shared SRAM-like memory port.
- Each side uses req/addr_ok/data_ok handshakes. The block keeps exactly one transaction in flight.
- Data requests have priority. A starvation counter guarantees the fetch side a grant.
- Sits between the pipeline front/back ends and the single memory bridge in the CPU top.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch request waits; range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data request; held until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte strobes for a store.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid or store complete this cycle.
- data_rdata  out  32  load data.
- mem_req  out  1  shared-port request.
- mem_wr  out  1  shared-port write flag.
- mem_size  out  2  shared-port size.
- mem_wstrb  out  4  shared-port strobes.
- mem_addr  out  32  shared-port address.
- mem_wdata  out  32  shared-port write data.
- mem_addr_ok  in  1  shared port accepted the request.
- mem_data_ok  in  1  shared port response valid.
- mem_rdata  in  32  shared port read data.

## Operation
State machine: IDLE -> ADDR -> DATA -> IDLE. Registers:
- owner (0 = inst, 1 = data).
- latched wr, size, wstrb, addr, wdata.
- starve_cnt, 4 bits.

IDLE:
- Winner selection:
  - If inst_req and (starve_cnt == STARVE_LIMIT or !data_req), the winner is inst.
  - Otherwise, if data_req, the winner is data.
- The winner's addr_ok is 1 combinationally this cycle. Its fields are latched and owner is set. Next state is ADDR.
- A fetch is latched as wr=0, size=2, wstrb=0, wdata=0.
- No request: stay in IDLE.

starve_cnt, updated on each IDLE grant:
- Cleared on an inst grant.
- Incremented when data is granted while inst_req = 1. It saturates at STARVE_LIMIT.
- Unchanged when data is granted while inst_req = 0.

ADDR:
- mem_req = 1. mem_* carry the latched fields.
- On mem_addr_ok, go to DATA. Otherwise hold, with mem_* stable.

DATA:
- mem_req = 0.
- On mem_data_ok: owner's data_ok = 1 and owner's rdata = mem_rdata, same cycle. Go to IDLE.

General rules:
- Both addr_ok outputs are 0 outside IDLE. Both data_ok outputs are 0 outside DATA.
- The non-owner data_ok is always 0.
- inst_rdata and data_rdata are 0 whenever their data_ok is 0.
- mem_rdata is ignored for store responses; data_rdata returns 0.
- Spurious mem_data_ok in IDLE or ADDR is ignored.
- Requesters drop req in the cycle after addr_ok. A req still high in IDLE is a new request.

## Timing
- Reset values:
  - State IDLE, owner 0, starve_cnt 0, all latched fields 0.
  - All outputs 0.
- Reset in ADDR or DATA abandons the transaction. No data_ok is issued for it.
- Acceptance latency: addr_ok in the same cycle as req when the state is IDLE.
- Minimum transaction: 3 cycles (IDLE accept, ADDR with mem_addr_ok=1, DATA with mem_data_ok=1). Throughput is at most 1 transaction per 3 cycles.
- mem_req rises exactly 1 cycle after the requester's addr_ok.
- Response timing: requester data_ok = mem_data_ok in the DATA cycle, with zero added latency.
- Simultaneous inst_req and data_req in IDLE: exactly one addr_ok is asserted, never both.
- Wait states: mem_addr_ok low for N cycles extends ADDR by N. mem_data_ok low for M cycles extends DATA by M.

## Test plan
- Reset: hold reset 3 cycles with random inputs.
  - All outputs 0.
  - First cycle after release: inst_req=1, addr 0x1C000000 gives inst_addr_ok=1.
- Single fetch, zero wait:
  - inst_addr_ok at T0.
  - mem_req=1 with mem_addr=0x1C000000, mem_wr=0, mem_size=2 at T1.
  - At T2, mem_data_ok with mem_rdata=0x02800C0C gives inst_data_ok=1 and inst_rdata=0x02800C0C. data_data_ok stays 0.
- Store with wait states:
  - Request: data_wr=1, addr 0x00001004, wstrb 0b1100, wdata 0xAABB0000.
  - mem_addr_ok delayed 2 cycles: mem fields stay stable for 3 ADDR cycles.
  - mem_data_ok delayed 1 cycle: data_data_ok=1 and data_rdata=0 on the 2nd DATA cycle.
- Priority and starvation (STARVE_LIMIT=4):
  - inst_req and data_req both held high continuously.
  - Grants are data ×4, inst, data ×4, inst.
  - starve_cnt reads 0,1,2,3,4,0.
- Reset mid-transaction:
  - Assert reset during DATA of a load to 0x2000.
  - Next cycle: state IDLE and mem_req=0.
  - A later mem_data_ok with no new accepted request produces no data_ok.
- Spurious response: mem_data_ok=1 in IDLE and in ADDR -> inst_data_ok=0 and data_data_ok=0.
